// File: rtl/axi_native_pkg.sv
// Shared types and constants for the AXI read to LiteDRAM native-port bridge.
package axi_native_pkg;

   localparam int DATA_W     = 256;
   localparam int WORD_SHIFT = 5;

   localparam logic [1:0] RESP_OKAY    = 2'd0;
   localparam logic [1:0] RESP_SLVERR  = 2'd2;
   localparam logic [3:0] AXI_SIZE_32B = 4'd5;

   typedef enum logic [1:0] {
      FIXED = 2'd0,
      INCR  = 2'd1,
      WRAP  = 2'd2
   } burst_e;

   typedef struct packed {
      logic       id;
      logic [1:0] resp;
      logic       last;
   } rd_tag_t;

   // WRAP bursts are only legal for 2, 4, 8 or 16 beats.
   function automatic logic wrap_len_ok(input logic [7:0] len);
      return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
   endfunction

endpackage

// File: rtl/rd_tag_fifo.sv
// In-order tag FIFO holding the R-channel attributes of every native read in flight.
module rd_tag_fifo
   import axi_native_pkg::*;
#(
   parameter int  DEPTH = 8,
   parameter type T     = rd_tag_t
) (
   input  logic clk,
   input  logic rst,
   input  logic push,
   input  T     push_data,
   input  logic pop,
   output T     head,
   output logic full,
   output logic empty
);

   localparam int PTR_W = $clog2(DEPTH);

   T                 mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic             do_push;
   logic             do_pop;

   // Full is judged on the current count only, so a same-cycle pop never frees a slot early.
   assign full    = (count == (PTR_W + 1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/axi_rd_to_native.sv
// AXI4 read bursts to LiteDRAM native single-beat reads, with in-order R tagging.
// Define AXI_RD_R_SKID_EN for a registered 2-entry skid buffer on the R channel.
//
// state   | meaning
// S_IDLE  | waiting for an AR request, axi_ar_ready high
// S_ISSUE | issuing one native read per beat of the latched burst
module axi_rd_to_native
   import axi_native_pkg::*;
#(
   parameter int OUTSTANDING_DEPTH = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              axi_ar_valid,
   output logic              axi_ar_ready,
   input  logic [31:0]       axi_ar_payload_addr,
   input  logic [1:0]        axi_ar_payload_burst,
   input  logic [7:0]        axi_ar_payload_len,
   input  logic [3:0]        axi_ar_payload_size,
   input  logic              axi_ar_payload_id,
   output logic              axi_r_valid,
   input  logic              axi_r_ready,
   output logic              axi_r_last,
   output logic [DATA_W-1:0] axi_r_payload_data,
   output logic [1:0]        axi_r_payload_resp,
   output logic              axi_r_payload_id,
   output logic              native_cmd_valid,
   input  logic              native_cmd_ready,
   output logic              native_cmd_payload_we,
   output logic              native_cmd_payload_mw,
   output logic [31:0]       native_cmd_payload_addr,
   input  logic              rdata_valid,
   output logic              rdata_ready,
   input  logic [DATA_W-1:0] rdata_payload_data
);

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_ISSUE = 1'b1;

   logic [0:0]  state;
   logic [31:0] addr_q;
   logic [8:0]  beats_q;
   logic [7:0]  len_q;
   burst_e      mode_q;
   logic        id_q;
   logic        err_q;

   logic        ar_fire;
   logic        cmd_fire;
   logic        ar_err;
   burst_e      ar_mode;
   logic [31:0] addr_inc;
   logic [31:0] wrap_mask;
   logic [31:0] addr_nxt;

   rd_tag_t     push_tag;
   rd_tag_t     head_tag;
   logic        tag_full;
   logic        tag_empty;
   logic        tag_pop;

   assign axi_ar_ready = (state == S_IDLE);
   assign ar_fire      = axi_ar_valid && axi_ar_ready;

   // Illegal bursts still issue every beat; unusable burst types fall back to INCR addressing.
   always_comb begin
      ar_err  = (axi_ar_payload_size != AXI_SIZE_32B) || (axi_ar_payload_burst == 2'd3) ||
                ((axi_ar_payload_burst == 2'd2) && !wrap_len_ok(axi_ar_payload_len));
      ar_mode = INCR;
      case (axi_ar_payload_burst)
         2'd0:    ar_mode = FIXED;
         2'd2:    ar_mode = wrap_len_ok(axi_ar_payload_len) ? WRAP : INCR;
         default: ar_mode = INCR;
      endcase
   end

   assign addr_inc  = addr_q + 32'd1;
   assign wrap_mask = {24'd0, len_q};

   always_comb begin
      addr_nxt = addr_inc;
      case (mode_q)
         FIXED:   addr_nxt = addr_q;
         WRAP:    addr_nxt = (addr_q & ~wrap_mask) | (addr_inc & wrap_mask);
         default: addr_nxt = addr_inc;
      endcase
   end

   assign native_cmd_valid        = (state == S_ISSUE) && !tag_full;
   assign native_cmd_payload_we   = 1'b0;
   assign native_cmd_payload_mw   = 1'b0;
   assign native_cmd_payload_addr = addr_q;
   assign cmd_fire                = native_cmd_valid && native_cmd_ready;

   assign push_tag = '{id:   id_q,
                       resp: (err_q ? RESP_SLVERR : RESP_OKAY),
                       last: (beats_q == 9'd1)};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         addr_q  <= '0;
         beats_q <= '0;
         len_q   <= '0;
         mode_q  <= INCR;
         id_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (ar_fire) begin
                  addr_q  <= axi_ar_payload_addr >> WORD_SHIFT;
                  beats_q <= {1'b0, axi_ar_payload_len} + 9'd1;
                  len_q   <= axi_ar_payload_len;
                  mode_q  <= ar_mode;
                  id_q    <= axi_ar_payload_id;
                  err_q   <= ar_err;
                  state   <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (cmd_fire) begin
                  addr_q  <= addr_nxt;
                  beats_q <= beats_q - 9'd1;
                  if (beats_q == 9'd1) state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   rd_tag_fifo #(
      .DEPTH (OUTSTANDING_DEPTH),
      .T     (rd_tag_t)
   ) u_tag_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (cmd_fire),
      .push_data (push_tag),
      .pop       (tag_pop),
      .head      (head_tag),
      .full      (tag_full),
      .empty     (tag_empty)
   );

`ifdef AXI_RD_R_SKID_EN
   logic              out_valid;
   logic              sk_valid;
   logic [DATA_W-1:0] out_data;
   logic [DATA_W-1:0] sk_data;
   rd_tag_t           out_tag;
   rd_tag_t           sk_tag;
   logic              in_fire;
   logic              out_fire;

   // A beat arriving with no tag outstanding is accepted and discarded.
   assign rdata_ready = !(out_valid && sk_valid);
   assign in_fire     = rdata_valid && rdata_ready && !tag_empty;
   assign tag_pop     = in_fire;
   assign out_fire    = out_valid && axi_r_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         sk_valid  <= 1'b0;
         out_data  <= '0;
         sk_data   <= '0;
         out_tag   <= '0;
         sk_tag    <= '0;
      end else if (out_fire || !out_valid) begin
         if (sk_valid) begin
            out_valid <= 1'b1;
            out_data  <= sk_data;
            out_tag   <= sk_tag;
            sk_valid  <= in_fire;
            if (in_fire) begin
               sk_data <= rdata_payload_data;
               sk_tag  <= head_tag;
            end
         end else begin
            out_valid <= in_fire;
            if (in_fire) begin
               out_data <= rdata_payload_data;
               out_tag  <= head_tag;
            end
         end
      end else if (in_fire) begin
         sk_valid <= 1'b1;
         sk_data  <= rdata_payload_data;
         sk_tag   <= head_tag;
      end
   end

   assign axi_r_valid        = out_valid;
   assign axi_r_payload_data = out_data;
   assign axi_r_last         = out_tag.last;
   assign axi_r_payload_resp = out_tag.resp;
   assign axi_r_payload_id   = out_tag.id;
`else
   rd_tag_t head_vis;

   assign head_vis           = tag_empty ? rd_tag_t'('0) : head_tag;
   assign axi_r_valid        = rdata_valid && !tag_empty;
   assign rdata_ready        = axi_r_ready || tag_empty;
   assign tag_pop            = axi_r_valid && axi_r_ready;
   assign axi_r_payload_data = rdata_payload_data;
   assign axi_r_last         = head_vis.last;
   assign axi_r_payload_resp = head_vis.resp;
   assign axi_r_payload_id   = head_vis.id;
`endif

endmodule

// File: tb/tb_axi_rd_to_native.sv
// Directed bench for axi_rd_to_native: burst-level model plus literal address/tag checks.
`timescale 1ns/1ps
module tb_axi_rd_to_native;

   localparam int DEPTH = 8;
`ifdef AXI_RD_R_SKID_EN
   localparam int R_LAT = 2;
`else
   localparam int R_LAT = 1;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         axi_ar_valid;
   logic         axi_ar_ready;
   logic [31:0]  axi_ar_payload_addr;
   logic [1:0]   axi_ar_payload_burst;
   logic [7:0]   axi_ar_payload_len;
   logic [3:0]   axi_ar_payload_size;
   logic         axi_ar_payload_id;
   logic         axi_r_valid;
   logic         axi_r_ready;
   logic         axi_r_last;
   logic [255:0] axi_r_payload_data;
   logic [1:0]   axi_r_payload_resp;
   logic         axi_r_payload_id;
   logic         native_cmd_valid;
   logic         native_cmd_ready;
   logic         native_cmd_payload_we;
   logic         native_cmd_payload_mw;
   logic [31:0]  native_cmd_payload_addr;
   logic         rdata_valid;
   logic         rdata_ready;
   logic [255:0] rdata_payload_data;

   axi_rd_to_native #(.OUTSTANDING_DEPTH(DEPTH)) dut (
      .clk                     (clk),
      .rst                     (rst),
      .axi_ar_valid            (axi_ar_valid),
      .axi_ar_ready            (axi_ar_ready),
      .axi_ar_payload_addr     (axi_ar_payload_addr),
      .axi_ar_payload_burst    (axi_ar_payload_burst),
      .axi_ar_payload_len      (axi_ar_payload_len),
      .axi_ar_payload_size     (axi_ar_payload_size),
      .axi_ar_payload_id       (axi_ar_payload_id),
      .axi_r_valid             (axi_r_valid),
      .axi_r_ready             (axi_r_ready),
      .axi_r_last              (axi_r_last),
      .axi_r_payload_data      (axi_r_payload_data),
      .axi_r_payload_resp      (axi_r_payload_resp),
      .axi_r_payload_id        (axi_r_payload_id),
      .native_cmd_valid        (native_cmd_valid),
      .native_cmd_ready        (native_cmd_ready),
      .native_cmd_payload_we   (native_cmd_payload_we),
      .native_cmd_payload_mw   (native_cmd_payload_mw),
      .native_cmd_payload_addr (native_cmd_payload_addr),
      .rdata_valid             (rdata_valid),
      .rdata_ready             (rdata_ready),
      .rdata_payload_data      (rdata_payload_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [255:0] data;
      logic         id;
      logic [1:0]   resp;
      logic         last;
   } r_exp_t;

   logic [31:0] exp_cmd [$];
   r_exp_t      exp_r [$];
   logic [31:0] mem_q [$];
   logic [31:0] cmd_log [$];
   logic [3:0]  r_log [$];

   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;
   int   cmd_cnt = 0;
   int   ar_cyc = -1;
   int   first_cmdv_cyc = -1;
   int   first_cmd_cyc = -1;
   int   first_r_cyc = -1;
   logic hold_rdata = 1'b0;
   logic rand_mode = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [255:0] mem_data(input logic [31:0] a);
      return {a, ~a, a ^ 32'hdead_beef, a + 32'h1234_5678, {a[15:0], a[31:16]},
              ~a ^ 32'h0f0f_0f0f, a * 32'd3, 32'hc0de_0000 | a};
   endfunction

   // Address of beat i, computed directly from the burst start rather than step by step.
   function automatic logic [31:0] beat_addr(input logic [31:0] w0, input logic [1:0] burst,
                                             input logic [7:0] len, input int i);
      logic [31:0] m;
      m = {24'd0, len};
      if (burst == 2'd0) return w0;
      if (burst == 2'd2 && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15))
         return (w0 & ~m) + ((w0 + 32'(i)) & m);
      return w0 + 32'(i);
   endfunction

   task automatic model_push(input logic [31:0] addr, input logic [1:0] burst,
                             input logic [7:0] len, input logic [3:0] size, input logic id);
      logic        err;
      logic [31:0] a;
      r_exp_t      r;
      err = (size != 4'd5) || (burst == 2'd3) ||
            (burst == 2'd2 && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
      for (int i = 0; i <= int'(len); i++) begin
         a = beat_addr(addr >> 5, burst, len, i);
         exp_cmd.push_back(a);
         r.data = mem_data(a);
         r.id   = id;
         r.resp = err ? 2'd2 : 2'd0;
         r.last = (i == int'(len));
         exp_r.push_back(r);
      end
   endtask

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Native port responder and random backpressure.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         axi_r_ready        = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
         native_cmd_ready   = rand_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
         rdata_valid        = !rst && !hold_rdata && (mem_q.size() > 0);
         rdata_payload_data = (mem_q.size() > 0) ? mem_data(mem_q[0]) : '0;
      end
   end

   // Compare process: every handshake about to happen on the next posedge is checked here.
   always @(negedge clk) begin
      r_exp_t e;
      if (!rst) begin
         if (axi_ar_valid && axi_ar_ready) begin
            model_push(axi_ar_payload_addr, axi_ar_payload_burst, axi_ar_payload_len,
                       axi_ar_payload_size, axi_ar_payload_id);
            ar_cyc = cyc;
         end
         if (native_cmd_valid && first_cmdv_cyc < 0) first_cmdv_cyc = cyc;
         chk("cmd_we_mw", 256'({native_cmd_payload_we, native_cmd_payload_mw}), 256'(0));
         if (native_cmd_valid && native_cmd_ready) begin
            cmd_cnt++;
            if (first_cmd_cyc < 0) first_cmd_cyc = cyc;
            cmd_log.push_back(native_cmd_payload_addr);
            if (exp_cmd.size() == 0) chk("cmd_unexpected", 256'(1), 256'(0));
            else chk("cmd_addr", 256'(native_cmd_payload_addr), 256'(exp_cmd.pop_front()));
            mem_q.push_back(native_cmd_payload_addr);
         end
         chk("r_valid_spurious", 256'(axi_r_valid && exp_r.size() == 0), 256'(0));
         if (axi_r_valid && first_r_cyc < 0) first_r_cyc = cyc;
         if (axi_r_valid && axi_r_ready && exp_r.size() > 0) begin
            e = exp_r.pop_front();
            chk("r_data", axi_r_payload_data, e.data);
            chk("r_id",   256'(axi_r_payload_id), 256'(e.id));
            chk("r_resp", 256'(axi_r_payload_resp), 256'(e.resp));
            chk("r_last", 256'(axi_r_last), 256'(e.last));
            r_log.push_back({axi_r_payload_id, axi_r_payload_resp, axi_r_last});
         end
         if (rdata_valid && rdata_ready) begin
            chk("rdata_without_cmd", 256'(mem_q.size() == 0), 256'(0));
            if (mem_q.size() > 0) void'(mem_q.pop_front());
         end
      end
   end

   task automatic send_ar(input logic [31:0] addr, input logic [1:0] burst, input logic [7:0] len,
                          input logic [3:0] size, input logic id);
      int n;
      n = 0;
      @(posedge clk);
      #2;
      axi_ar_valid         = 1'b1;
      axi_ar_payload_addr  = addr;
      axi_ar_payload_burst = burst;
      axi_ar_payload_len   = len;
      axi_ar_payload_size  = size;
      axi_ar_payload_id    = id;
      @(negedge clk);
      while (!axi_ar_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("ar_accept_timeout", 256'(n >= 200), 256'(0));
      @(posedge clk);
      #2;
      axi_ar_valid = 1'b0;
   endtask

   task automatic wait_drain(input string name, input int budget);
      int n;
      n = 0;
      while ((exp_r.size() != 0 || exp_cmd.size() != 0) && n < budget) begin
         @(posedge clk);
         n++;
      end
      chk({name, "_drain_timeout"}, 256'(n >= budget), 256'(0));
      repeat (2) @(posedge clk);
      #2;
   endtask

   task automatic clear_logs();
      cmd_log.delete();
      r_log.delete();
      cmd_cnt        = 0;
      first_cmdv_cyc = -1;
      first_cmd_cyc  = -1;
      first_r_cyc    = -1;
   endtask

   task automatic check_cmds(input string name, input logic [31:0] eq [$]);
      chk({name, "_cmd_count"}, 256'(cmd_log.size()), 256'(eq.size()));
      for (int i = 0; i < eq.size(); i++)
         if (i < cmd_log.size()) chk({name, "_cmd_lit"}, 256'(cmd_log[i]), 256'(eq[i]));
   endtask

   task automatic check_r(input string name, input logic [3:0] eq [$]);
      chk({name, "_r_count"}, 256'(r_log.size()), 256'(eq.size()));
      for (int i = 0; i < eq.size(); i++)
         if (i < r_log.size()) chk({name, "_r_tag_lit"}, 256'(r_log[i]), 256'(eq[i]));
   endtask

   task automatic check_reset_vals(input string name);
      chk({name, "_ar_ready"},  256'(axi_ar_ready), 256'(1));
      chk({name, "_cmd_valid"}, 256'(native_cmd_valid), 256'(0));
      chk({name, "_r_valid"},   256'(axi_r_valid), 256'(0));
      chk({name, "_r_last"},    256'(axi_r_last), 256'(0));
      chk({name, "_r_resp"},    256'(axi_r_payload_resp), 256'(0));
      chk({name, "_r_id"},      256'(axi_r_payload_id), 256'(0));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] aq [$];
      logic [3:0]  tq [$];
      int          n;

      rst                  = 1'b1;
      axi_ar_valid         = 1'b0;
      axi_ar_payload_addr  = '0;
      axi_ar_payload_burst = 2'd1;
      axi_ar_payload_len   = '0;
      axi_ar_payload_size  = 4'd5;
      axi_ar_payload_id    = 1'b0;
      axi_r_ready          = 1'b1;
      native_cmd_ready     = 1'b1;
      rdata_valid          = 1'b0;
      rdata_payload_data   = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_vals("reset");
      @(posedge clk);
      #2;
      rst = 1'b0;

      // 1: INCR, latency pins
      clear_logs();
      send_ar(32'h1000, 2'd1, 8'd3, 4'd5, 1'b1);
      wait_drain("t1", 100);
      aq = {32'h80, 32'h81, 32'h82, 32'h83};
      check_cmds("t1", aq);
      tq = {4'b1000, 4'b1000, 4'b1000, 4'b1001};
      check_r("t1", tq);
      chk("t1_ar_to_cmd_valid", 256'(first_cmdv_cyc - ar_cyc), 256'(1));
      chk("t1_cmd_to_r_latency", 256'(first_r_cyc - first_cmd_cyc), 256'(R_LAT));

      // 2: WRAP
      clear_logs();
      send_ar(32'h1060, 2'd2, 8'd3, 4'd5, 1'b0);
      wait_drain("t2", 100);
      aq = {32'h83, 32'h80, 32'h81, 32'h82};
      check_cmds("t2", aq);
      tq = {4'b0000, 4'b0000, 4'b0000, 4'b0001};
      check_r("t2", tq);

      // 3: FIXED, then error bursts (bad size, bad WRAP length, reserved burst)
      clear_logs();
      send_ar(32'h40, 2'd0, 8'd2, 4'd5, 1'b1);
      send_ar(32'h2000, 2'd1, 8'd0, 4'd4, 1'b0);
      send_ar(32'h3000, 2'd2, 8'd2, 4'd5, 1'b1);
      send_ar(32'h4020, 2'd3, 8'd1, 4'd5, 1'b0);
      wait_drain("t3", 200);
      aq = {32'h2, 32'h2, 32'h2, 32'h100, 32'h180, 32'h181, 32'h182, 32'h201, 32'h202};
      check_cmds("t3", aq);
      tq = {4'b1000, 4'b1000, 4'b1001, 4'b0101, 4'b1100, 4'b1100, 4'b1101, 4'b0100, 4'b0101};
      check_r("t3", tq);

      // 4: outstanding limit with read data held back
      clear_logs();
      hold_rdata = 1'b1;
      send_ar(32'h8000, 2'd1, 8'd15, 4'd5, 1'b0);
      repeat (30) @(posedge clk);
      @(negedge clk);
      chk("t4_cmds_while_held", 256'(cmd_cnt), 256'(DEPTH));
      chk("t4_cmd_valid_when_full", 256'(native_cmd_valid), 256'(0));
      @(posedge clk);
      #2;
      hold_rdata = 1'b0;
      wait_drain("t4", 400);
      aq.delete();
      tq.delete();
      for (int i = 0; i < 16; i++) begin
         aq.push_back(32'h400 + 32'(i));
         tq.push_back({3'b000, i == 15});
      end
      check_cmds("t4", aq);
      check_r("t4", tq);

      // 5: back-to-back bursts under random backpressure
      clear_logs();
      rand_mode = 1'b1;
      send_ar(32'h200, 2'd1, 8'd1, 4'd5, 1'b0);
      send_ar(32'h600, 2'd1, 8'd0, 4'd5, 1'b1);
      wait_drain("t5", 400);
      rand_mode = 1'b0;
      aq = {32'h10, 32'h11, 32'h30};
      check_cmds("t5", aq);
      tq = {4'b0000, 4'b0001, 4'b1001};
      check_r("t5", tq);

      // 6: reset in the middle of a burst, then a clean single-beat burst
      clear_logs();
      send_ar(32'h10000, 2'd1, 8'd7, 4'd5, 1'b1);
      n = 0;
      while (cmd_cnt < 2 && n < 50) begin
         @(posedge clk);
         n++;
      end
      chk("t6_wait_timeout", 256'(n >= 50), 256'(0));
      #2;
      rst = 1'b1;
      exp_cmd.delete();
      exp_r.delete();
      mem_q.delete();
      @(negedge clk);
      check_reset_vals("t6_reset");
      @(posedge clk);
      #2;
      rst = 1'b0;
      clear_logs();
      send_ar(32'h20000, 2'd1, 8'd0, 4'd5, 1'b0);
      wait_drain("t6", 100);
      aq = {32'h1000};
      check_cmds("t6", aq);
      tq = {4'b0001};
      check_r("t6", tq);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
